// File: rtl/conv_stream_ctrl_if.sv
// Stream handshake bundle for conv_stream_ctrl: capture-side input beats and
// filtered-pixel output beats with their qualifiers.
interface conv_stream_ctrl_if;
  logic in_valid;
  logic in_sop;
  logic in_eop;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic out_sop;
  logic out_eop;
  logic out_border;

  // Source/sink side: drives input beats and output back-pressure.
  modport master (
    output in_valid, in_sop, in_eop, out_ready,
    input  in_ready, out_valid, out_sop, out_eop, out_border
  );

  // Controller side.
  modport slave (
    input  in_valid, in_sop, in_eop, out_ready,
    output in_ready, out_valid, out_sop, out_eop, out_border
  );
endinterface

// File: rtl/conv_stream_ctrl.sv
// Frame sequencer for a 3x3 streaming convolution: drives line-buffer writes and
// window shifts, and emits one output beat per input pixel after an IMG_W+1 pipeline fill.
module conv_stream_ctrl #(
  parameter int unsigned IMG_W = 320,
  parameter int unsigned IMG_H = 240,
  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic              clk,
  input  logic              rst,
  conv_stream_ctrl_if.slave strm,
  output logic              lb_wr_en,
  output logic [1:0]        lb_wr_sel,
  output logic [CW-1:0]     lb_addr,
  output logic              win_shift,
  output logic              busy,
  output logic              err_frame
);

  localparam int unsigned RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned KMAX = NPIX + IMG_W;
  localparam int unsigned KW   = $clog2(KMAX + 1);

  localparam logic [CW-1:0] ColLast   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast   = RW'(IMG_H - 1);
  localparam logic [KW-1:0] KFirstOut = KW'(IMG_W + 1);
  localparam logic [KW-1:0] KLast     = KW'(KMAX);

  typedef enum logic [1:0] {StIdle, StStream, StFlush} state_e;

  state_e        r_state;
  logic [CW-1:0] r_in_col;
  logic [RW-1:0] r_in_row;
  logic [1:0]    r_sel;
  logic [KW-1:0] r_k;
  logic [CW-1:0] r_out_col;
  logic [RW-1:0] r_out_row;
  logic          r_out_valid;
  logic          r_out_sop;
  logic          r_out_eop;
  logic          r_out_border;
  logic          r_err;

  logic          w_out_free;
  logic          w_in_ready;
  logic          w_acc;
  logic          w_sop_beat;
  logic          w_frame_beat;
  logic          w_restart;
  logic          w_adv;
  logic          w_emit;
  logic          w_last_pix;
  logic          w_flush_done;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [1:0]    w_sel;
  logic [KW-1:0] w_k;

  assign w_out_free   = !r_out_valid || strm.out_ready;
  assign w_in_ready   = (r_state != StFlush) && w_out_free;
  assign w_acc        = strm.in_valid && w_in_ready;
  assign w_sop_beat   = w_acc && strm.in_sop;
  // Beats without sop are swallowed while idle.
  assign w_frame_beat = w_acc && (strm.in_sop || (r_state == StStream));
  assign w_restart    = w_sop_beat && (r_state == StStream);
  assign w_adv        = w_frame_beat || ((r_state == StFlush) && w_out_free);

  // A sop beat is pixel 0 regardless of where the counters stand.
  assign w_col = w_sop_beat ? '0 : r_in_col;
  assign w_row = w_sop_beat ? '0 : r_in_row;
  assign w_sel = w_sop_beat ? '0 : r_sel;
  assign w_k   = w_sop_beat ? '0 : r_k;

  assign w_last_pix   = (w_col == ColLast) && (w_row == RowLast);
  assign w_emit       = w_adv && (w_k >= KFirstOut);
  assign w_flush_done = (r_state == StFlush) && w_adv && (r_k == KLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_in_col     <= '0;
      r_in_row     <= '0;
      r_sel        <= '0;
      r_k          <= '0;
      r_out_col    <= '0;
      r_out_row    <= '0;
      r_out_valid  <= 1'b0;
      r_out_sop    <= 1'b0;
      r_out_eop    <= 1'b0;
      r_out_border <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err <= w_frame_beat && (w_restart || (strm.in_eop != w_last_pix));

      if (w_frame_beat) begin
        if (w_last_pix) begin
          r_in_col <= '0;
          r_in_row <= '0;
          r_sel    <= '0;
          r_state  <= StFlush;
        end else begin
          r_state <= StStream;
          if (w_col == ColLast) begin
            r_in_col <= '0;
            r_in_row <= w_row + RW'(1);
            r_sel    <= (w_sel == 2'd2) ? 2'd0 : w_sel + 2'd1;
          end else begin
            r_in_col <= w_col + CW'(1);
            r_in_row <= w_row;
            r_sel    <= w_sel;
          end
        end
      end

      if (w_adv) begin
        r_k <= w_k + KW'(1);
      end

      if (w_flush_done) begin
        r_state <= StIdle;
        r_k     <= '0;
      end

      if (w_sop_beat) begin
        r_out_col <= '0;
        r_out_row <= '0;
      end

      // Output register only reloads when the previous beat has left.
      if (w_emit) begin
        r_out_valid  <= 1'b1;
        r_out_sop    <= (r_out_col == '0) && (r_out_row == '0);
        r_out_eop    <= (r_out_col == ColLast) && (r_out_row == RowLast);
        r_out_border <= (r_out_row == '0) || (r_out_row == RowLast) ||
                        (r_out_col == '0) || (r_out_col == ColLast);
        if (r_out_col == ColLast) begin
          r_out_col <= '0;
          r_out_row <= (r_out_row == RowLast) ? '0 : r_out_row + RW'(1);
        end else begin
          r_out_col <= r_out_col + CW'(1);
        end
      end else if (strm.out_ready) begin
        r_out_valid  <= 1'b0;
        r_out_sop    <= 1'b0;
        r_out_eop    <= 1'b0;
        r_out_border <= 1'b0;
      end
    end
  end

  assign strm.in_ready   = w_in_ready;
  assign strm.out_valid  = r_out_valid;
  assign strm.out_sop    = r_out_sop;
  assign strm.out_eop    = r_out_eop;
  assign strm.out_border = r_out_border;

  assign lb_wr_en  = w_frame_beat;
  assign lb_wr_sel = w_sel;
  assign lb_addr   = w_col;
  assign win_shift = w_adv;
  assign busy      = (r_state != StIdle);
  assign err_frame = r_err;

endmodule

// File: doc/conv_stream_ctrl.md
CONV_STREAM_CTRL -- requirements
Module: conv_stream_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 320: active pixels per line.
REQ-002 SHALL have parameter IMG_H, default 240: active lines per frame.
REQ-003 SHALL have port clk  in  1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid  in  1: capture beat offered.
REQ-006 SHALL have port in_sop  in  1: beat is pixel (0,0).
REQ-007 SHALL have port in_eop  in  1: beat is pixel (IMG_H-1,IMG_W-1).
REQ-008 SHALL have port in_ready  out  1: beat accepted when in_valid&in_ready.
REQ-009 SHALL have port lb_wr_en  out  1: write accepted pixel to line buffer lb_wr_sel at lb_addr.
REQ-010 SHALL have port lb_wr_sel  out  2: active line buffer, 0..2.
REQ-011 SHALL have port lb_addr  out  clog2(IMG_W): input column.
REQ-012 SHALL have port win_shift  out  1: datapath shifts 3x3 window one column.
REQ-013 SHALL have port out_valid / out_ready  out / in  1 each: filtered pixel handshake.
REQ-014 SHALL have ports out_sop, out_eop, out_border  out  1 each: qualify the out_valid beat.
REQ-015 SHALL have port busy  out  1: state is not IDLE.
REQ-016 SHALL have port err_frame  out  1: one-cycle framing-error pulse.

Function
REQ-017 SHALL implement states IDLE, STREAM, FLUSH.
REQ-018 SHALL define advance adv = (in_valid&in_ready in IDLE with in_sop, or in STREAM) | (FLUSH & (!out_valid|out_ready)).
REQ-019 SHALL drive in_ready = (state!=FLUSH) & (!out_valid|out_ready).
REQ-020 SHALL, in IDLE, accept and drop beats without in_sop (no adv, no lb write); sop beat is input pixel 0 and enters STREAM.
REQ-021 SHALL keep input counters in_col (0..IMG_W-1) and in_row (0..IMG_H-1), incrementing per accepted beat with column wrap into row increment.
REQ-022 SHALL drive lb_wr_en = accepted frame beat (combinational), lb_addr = in_col, lb_wr_sel rotating 0->1->2->0 at each row wrap, reset to 0 at sop.
REQ-023 SHALL drive win_shift = adv.
REQ-024 SHALL, on accepting input pixel IMG_W*IMG_H-1, enter FLUSH and generate exactly IMG_W+1 adv beats with no input, then return to IDLE.
REQ-025 SHALL count adv beats k from 0 at sop; for k >= IMG_W+1, register an output beat for pixel k-(IMG_W+1), visible the cycle after that adv.
REQ-026 SHALL hold out_valid and qualifiers stable while out_valid & !out_ready.
REQ-027 SHALL keep output counters out_col/out_row; out_sop at (0,0), out_eop at (IMG_H-1,IMG_W-1).
REQ-028 SHALL assert out_border when out_row is 0 or IMG_H-1, or out_col is 0 or IMG_W-1.
REQ-029 SHALL emit exactly IMG_W*IMG_H output beats per completed frame.
REQ-030 SHALL pulse err_frame when in_eop is set on any beat other than pixel IMG_W*IMG_H-1, or is clear on that beat; frame length still governed by counters.
REQ-031 SHALL, on in_sop accepted in STREAM, pulse err_frame, zero all counters and lb_wr_sel, treat the beat as new pixel 0; a pending out_valid beat is still held until accepted.
REQ-032 SHALL ignore in_sop during FLUSH (in_ready low); the new frame starts from IDLE.

Reset
REQ-033 SHALL, while rst high, force IDLE, all counters 0, lb_wr_sel 0, out_valid/out_sop/out_eop/out_border/err_frame/busy 0; rst mid-frame abandons the frame with no further outputs.
REQ-034 SHALL drive in_ready 1 in the first cycle after rst deasserts.

Verification (IMG_W=4, IMG_H=3)
REQ-035 SHALL cover: 12 beats sop..eop, out_ready=1 -> first out_valid one cycle after 6th accepted beat, 12 outputs, out_sop on 1st, out_eop on 12th, 5 FLUSH cycles, busy low afterward.
REQ-036 SHALL cover: out_ready low for 3 cycles mid-frame -> in_ready low, out_valid held with identical qualifiers, no beat lost or duplicated.
REQ-037 SHALL cover: border check -> out_border=1 for outputs 0-4 and 7-11, 0 for outputs 5,6.
REQ-038 SHALL cover: in_eop on beat 7 -> err_frame one-cycle pulse, frame still completes with 12 outputs.
REQ-039 SHALL cover: in_sop on beat 5 -> err_frame pulse, counters restart, lb_wr_sel=0, lb_addr=0 on that beat.
REQ-040 SHALL cover: rst asserted during FLUSH -> next cycle IDLE, out_valid=0, busy=0; no-sop beats afterward produce no lb_wr_en.
